// File: rtl/gb_lcd_transmitter.sv
// gb_lcd_transmitter: Game Boy LCD-style dot clock, syncs and 2-bit pixel stream from a fetch interface.
// Define GB_TX_TEST_PATTERN_EN to replace PIX_DATA with an 8x8 diagonal stripe pattern.
module gb_lcd_transmitter #(
  parameter int CLK_DIV      = 12,
  parameter int HSYNC_DOTS   = 8,
  parameter int H_PIXELS     = 160,
  parameter int H_BLANK_DOTS = 288,
  parameter int V_ACTIVE     = 144,
  parameter int V_TOTAL      = 154
) (
  input  logic       SYSTEM_CLOCK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  output logic       PIX_RD,
  output logic [7:0] PIX_X,
  output logic [7:0] PIX_Y,
  input  logic [1:0] PIX_DATA,
  output logic       GB_PIXEL_CLOCK,
  output logic       GB_HSYNC,
  output logic       GB_VSYNC,
  output logic [1:0] GB_DATA,
  output logic       FRAME_START
);
  localparam int LINE_DOTS = HSYNC_DOTS + H_PIXELS + H_BLANK_DOTS;
  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(LINE_DOTS);
  localparam int LW = $clog2(V_TOTAL);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_CAP = PW'(1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2);
  localparam logic [DW-1:0] HS_DOTS = DW'(HSYNC_DOTS);
  localparam logic [DW-1:0] HS_LAST = DW'(HSYNC_DOTS - 1);
  localparam logic [DW-1:0] ACT_LAST = DW'(HSYNC_DOTS + H_PIXELS - 1);
  localparam logic [DW-1:0] DOT_LAST = DW'(LINE_DOTS - 1);
  localparam logic [LW-1:0] LN_ACT = LW'(V_ACTIVE);
  localparam logic [LW-1:0] LN_LAST = LW'(V_TOTAL - 1);
  typedef enum logic [1:0] {IDLE, HSYNC, ACTIVE, HBLANK} state_t;
  state_t state, nxt_state;
  logic [PW-1:0] phase, nxt_phase;
  logic [DW-1:0] dot, nxt_dot;
  logic [LW-1:0] line, nxt_line;
  logic end_dot, end_line, end_frame;
  logic [1:0] pix_val;
`ifdef GB_TX_TEST_PATTERN_EN
  logic unused_pix_data;
  assign unused_pix_data = ^PIX_DATA;
  assign pix_val = PIX_X[4:3] + PIX_Y[4:3];
`else
  assign pix_val = PIX_DATA;
`endif
  always_comb begin
    end_dot = phase == PH_LAST;
    end_line = end_dot && dot == DOT_LAST;
    end_frame = end_line && line == LN_LAST;
    nxt_phase = (state == IDLE || end_dot) ? '0 : phase + 1'b1;
    nxt_dot = (state == IDLE || end_line) ? '0 : end_dot ? dot + 1'b1 : dot;
    nxt_line = (state == IDLE || end_frame) ? '0 : end_line ? line + 1'b1 : line;
    nxt_state = state;
    unique case (state)
      IDLE:    nxt_state = ENABLE ? HSYNC : IDLE;
      HSYNC:   if (end_dot && dot == HS_LAST) nxt_state = line < LN_ACT ? ACTIVE : HBLANK;
      ACTIVE:  if (end_dot && dot == ACT_LAST) nxt_state = HBLANK;
      HBLANK:  if (end_line) nxt_state = (end_frame && !ENABLE) ? IDLE : HSYNC;
      default: nxt_state = IDLE;
    endcase
  end
  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge SYSTEM_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      phase <= '0;
      dot <= '0;
      line <= '0;
      PIX_RD <= 1'b0;
      PIX_X <= '0;
      PIX_Y <= '0;
      GB_PIXEL_CLOCK <= 1'b0;
      GB_HSYNC <= 1'b0;
      GB_VSYNC <= 1'b0;
      GB_DATA <= '0;
      FRAME_START <= 1'b0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      dot <= nxt_dot;
      line <= nxt_line;
      FRAME_START <= nxt_state == HSYNC && nxt_line == '0 && nxt_dot == '0 && nxt_phase == '0;
      GB_HSYNC <= nxt_state == HSYNC;
      GB_VSYNC <= nxt_state != IDLE && nxt_line == '0;
      PIX_RD <= nxt_state == ACTIVE && nxt_phase == '0;
      GB_PIXEL_CLOCK <= nxt_state == ACTIVE && nxt_phase > PH_RISE;
      if (nxt_state == ACTIVE && nxt_phase == '0) begin
        PIX_X <= 8'(nxt_dot - HS_DOTS);
        PIX_Y <= 8'(nxt_line);
      end
      if (state == ACTIVE && phase == PH_CAP) GB_DATA <= pix_val;
    end
  end
endmodule

// File: tb/tb_gb_lcd_transmitter.sv
// tb_gb_lcd_transmitter: checks the transmitter cycle by cycle against a frame-timeline model.
module tb_gb_lcd_transmitter;
  localparam int CD = 4, HS = 2, HP = 4, HB = 2, VA = 3, VT = 5;
  localparam int LD = HS + HP + HB, LC = LD * CD, FT = LC * VT;
  logic SYSTEM_CLOCK = 1'b0, RESET_N = 1'b0, ENABLE = 1'b0;
  logic [1:0] PIX_DATA = 2'd0;
  logic PIX_RD, GB_PIXEL_CLOCK, GB_HSYNC, GB_VSYNC, FRAME_START;
  logic [7:0] PIX_X, PIX_Y;
  logic [1:0] GB_DATA;
  int checks = 0, errors = 0;
  logic [1:0] img [4][4];
  logic [1:0] exp_data = 2'd0;
  logic [7:0] exp_x = 8'd0, exp_y = 8'd0;
  int n_pclk, n_rd, n_hs, n_vs, n_vb, n_fs_cyc, n_hs_cyc, n_vs_cyc;
  logic prev_pc, prev_hs, prev_vs;
  logic [1:0] prev_data;

  always #5 SYSTEM_CLOCK = ~SYSTEM_CLOCK;

  gb_lcd_transmitter #(.CLK_DIV(CD), .HSYNC_DOTS(HS), .H_PIXELS(HP), .H_BLANK_DOTS(HB),
                       .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .SYSTEM_CLOCK(SYSTEM_CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .PIX_RD(PIX_RD),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_DATA(PIX_DATA), .GB_PIXEL_CLOCK(GB_PIXEL_CLOCK),
    .GB_HSYNC(GB_HSYNC), .GB_VSYNC(GB_VSYNC), .GB_DATA(GB_DATA), .FRAME_START(FRAME_START));

`ifdef GB_TX_TEST_PATTERN_EN
  logic pat_en = 1'b0, p_pc;
  logic [4:0] pat_unused;
  logic [7:0] p_x, p_y;
  logic [1:0] p_d;
  gb_lcd_transmitter #(.CLK_DIV(4), .H_BLANK_DOTS(2)) u_pat (
    .SYSTEM_CLOCK(SYSTEM_CLOCK), .RESET_N(RESET_N), .ENABLE(pat_en), .PIX_RD(pat_unused[0]),
    .PIX_X(p_x), .PIX_Y(p_y), .PIX_DATA(2'b00), .GB_PIXEL_CLOCK(p_pc),
    .GB_HSYNC(pat_unused[1]), .GB_VSYNC(pat_unused[2]), .GB_DATA(p_d), .FRAME_START(pat_unused[3]));
  assign pat_unused[4] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; PIX_DATA answers a fetch during the following cycle, otherwise carries noise.
  task automatic tick();
    logic rd = PIX_RD;
    logic [1:0] v = img[PIX_Y[1:0]][PIX_X[1:0]];
    @(posedge SYSTEM_CLOCK);
    #1;
    PIX_DATA = rd ? v : 2'($urandom);
  endtask

  function automatic logic [1:0] pix(input int k, input int y);
`ifdef GB_TX_TEST_PATTERN_EN
    return 2'(k[4:3] + y[4:3]);
`else
    return img[y[1:0]][k[1:0]];
`endif
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_rd"}, PIX_RD, 0);
    chk({tag, "_pclk"}, GB_PIXEL_CLOCK, 0);
    chk({tag, "_hsync"}, GB_HSYNC, 0);
    chk({tag, "_vsync"}, GB_VSYNC, 0);
    chk({tag, "_fs"}, FRAME_START, 0);
    chk({tag, "_data"}, GB_DATA, 0);
    chk({tag, "_x"}, PIX_X, 0);
    chk({tag, "_y"}, PIX_Y, 0);
  endtask

  task automatic clear_counts();
    {n_pclk, n_rd, n_hs, n_vs, n_vb, n_fs_cyc, n_hs_cyc, n_vs_cyc} = '0;
  endtask

  task automatic randomize_img();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) img[y][x] = 2'($urandom);
  endtask

  // Walks one frame from its FRAME_START cycle; outputs are a pure function of the frame offset t.
  task automatic run_frame(input int drop_at, input int rst_at);
    int w = 0;
    while (FRAME_START !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    chk("frame_start_seen", FRAME_START, 1);
    if (FRAME_START !== 1'b1) return;
    for (int t = 0; t < FT; t++) begin
      int ln = t / LC, d = (t / CD) % LD, p = t % CD, k = d - HS;
      bit act = ln < VA && d >= HS && d < HS + HP;
      if (t == drop_at) ENABLE = 1'b0;
      if (act && p == 0) begin
        exp_x = 8'(k);
        exp_y = 8'(ln);
      end
      if (act && p == 2) exp_data = pix(k, ln);
      chk("fs", FRAME_START, t == 0);
      chk("hsync", GB_HSYNC, d < HS);
      chk("vsync", GB_VSYNC, ln == 0);
      chk("pix_rd", PIX_RD, act && p == 0);
      chk("pclk", GB_PIXEL_CLOCK, act && p > CD / 2);
      chk("gb_data", GB_DATA, exp_data);
      chk("pix_x", PIX_X, exp_x);
      chk("pix_y", PIX_Y, exp_y);
      if (GB_PIXEL_CLOCK && !prev_pc) begin
        n_pclk++;
        chk("data_at_edge", GB_DATA, pix(k, ln));
        chk("data_setup", prev_data, pix(k, ln));
      end
      if (GB_HSYNC && !prev_hs) n_hs++;
      if (GB_VSYNC && !prev_vs) n_vs++;
      if (ln >= VA && (PIX_RD || GB_PIXEL_CLOCK)) n_vb++;
      n_rd += int'(PIX_RD);
      n_fs_cyc += int'(FRAME_START);
      n_hs_cyc += int'(GB_HSYNC);
      n_vs_cyc += int'(GB_VSYNC);
      {prev_pc, prev_hs, prev_vs, prev_data} = {GB_PIXEL_CLOCK, GB_HSYNC, GB_VSYNC, GB_DATA};
      if (t == rst_at) begin
        RESET_N = 1'b0;
        #1;
        check_zero("async_rst");
        {exp_data, exp_x, exp_y, prev_pc, prev_hs, prev_vs, prev_data} = '0;
        return;
      end
      tick();
    end
  endtask

  initial begin
    {prev_pc, prev_hs, prev_vs, prev_data} = '0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) img[y][x] = 2'(x ^ y);
    #1;
    for (int i = 0; i < 6; i++) begin
      ENABLE = ~ENABLE;
      tick();
      check_zero("in_reset");
    end
    ENABLE = 1'b1;
    RESET_N = 1'b1;
    clear_counts();
    run_frame(-1, -1);
    chk("first_fs_cycles", n_fs_cyc, 1);
    chk("first_hsync_cycles", n_hs_cyc, VT * HS * CD);
    chk("first_vsync_cycles", n_vs_cyc, LC);
    run_frame(-1, -1);
    chk("two_frame_pclk", n_pclk, 2 * VA * HP);
    chk("two_frame_rd", n_rd, 2 * VA * HP);
    chk("two_frame_hsync", n_hs, 2 * VT);
    chk("two_frame_vsync", n_vs, 2);
    chk("vblank_activity", n_vb, 0);
    randomize_img();
    run_frame(-1, -1);
    randomize_img();
    run_frame(int'($urandom_range(1, FT - 2)), -1);
    for (int i = 0; i < 20; i++) begin
      chk("stop_fs", FRAME_START, 0);
      chk("stop_hsync", GB_HSYNC, 0);
      chk("stop_vsync", GB_VSYNC, 0);
      chk("stop_pclk", GB_PIXEL_CLOCK, 0);
      chk("stop_rd", PIX_RD, 0);
      chk("stop_data", GB_DATA, exp_data);
      chk("stop_x", PIX_X, HP - 1);
      chk("stop_y", PIX_Y, VA - 1);
      tick();
    end
    ENABLE = 1'b1;
    randomize_img();
    run_frame(-1, LC + (HS + int'($urandom_range(0, HP - 1))) * CD + 2);
    tick();
    check_zero("held_reset");
    RESET_N = 1'b1;
    randomize_img();
    clear_counts();
    run_frame(-1, -1);
    chk("restart_fs_cycles", n_fs_cyc, 1);
    chk("restart_pclk", n_pclk, VA * HP);
`ifdef GB_TX_TEST_PATTERN_EN
    begin
      int hits = 0;
      pat_en = 1'b1;
      for (int c = 0; c < 25000 && hits < 4; c++) begin
        if (p_pc) begin
          if (p_x == 8 && p_y == 0) begin chk("pat_8_0", p_d, 1); hits++; end
          if (p_x == 8 && p_y == 8) begin chk("pat_8_8", p_d, 2); hits++; end
          if (p_x == 31 && p_y == 24) begin chk("pat_31_24", p_d, 2); hits++; end
          if (p_x == 0 && p_y == 32) begin chk("pat_0_32", p_d, 0); hits++; end
        end
        tick();
      end
      chk("pat_hits", hits, 4);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
